// File: rtl/column_fetch.sv
// Column fetcher: on each theta strobe, reads one 2x NUM_ROWS-pixel column from the frame BRAM and offers it downstream.
// Latency: a strobe in IDLE at cycle 0 raises tvalid at cycle 2*NUM_ROWS+BRAM_LATENCY+1; the first read issues at cycle 1.
// Backpressure: the column is held until tvalid&&tready. One pending strobe is buffered; overwriting it sets sticky overrun.
// Build option: define TEST_PATTERN_EN to capture (theta+k) instead of BRAM data; the BRAM is then never read.
module column_fetch #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int NUM_ROWS       = 64,
    parameter int SCAN_RATE      = 32,
    parameter int RGB_RES        = 9,
    parameter int BRAM_LATENCY   = 2
) (
    input  logic                                              clk_in,
    input  logic                                              rst_n_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0]                 theta_in,
    input  logic                                              theta_valid,
    output logic [$clog2(ROTATIONAL_RES*2*NUM_ROWS)-1:0]      mem_addr,
    output logic                                              mem_rd_en,
    input  logic [RGB_RES-1:0]                                mem_rdata,
    output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]             column_data,
    output logic [$clog2(SCAN_RATE)-1:0]                      col_index,
    output logic                                              tvalid,
    input  logic                                              tready,
    output logic                                              overrun
);
    localparam int TW  = $clog2(ROTATIONAL_RES);
    localparam int AW  = $clog2(ROTATIONAL_RES*2*NUM_ROWS);
    localparam int CW  = $clog2(SCAN_RATE);
    localparam int KW  = $clog2(2*NUM_ROWS);
    localparam int PW  = $clog2(NUM_ROWS);
    localparam int LAT = BRAM_LATENCY;
    localparam int DW  = $clog2(LAT+1);

    localparam logic [KW-1:0] K_LAST     = KW'(2*NUM_ROWS-1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT-1);
    localparam logic [CW-1:0] IDX_LAST   = CW'(SCAN_RATE-1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

    state_t          state;
    logic [KW-1:0]   k_q;          // word index of the read currently on mem_addr
    logic            rd_issue;     // a read is issued this cycle (internal even in pattern mode)
    logic [DW-1:0]   drain_cnt;
    logic            pend_vld;
    logic [TW-1:0]   pend_theta;
    logic [TW-1:0]   start_theta;
    logic            xfer;

    // Read pipe mirroring the BRAM latency, tagging each returning word with its index
    logic            pipe_vld [LAT];
    logic [KW-1:0]   pipe_k   [LAT];
    logic            cap_h;
    logic [PW-1:0]   cap_p;
    logic [RGB_RES-1:0] cap_word;

`ifdef TEST_PATTERN_EN
    logic [TW-1:0]   theta_q;      // theta of the column being assembled, source of the pattern
`endif

    // A fresh strobe takes priority over the buffered one when a new fetch starts
    always_comb begin
        start_theta = theta_valid ? theta_in : pend_theta;
        xfer        = (state == VALID) && tready;
    end

    // Main sequencer: fetch, drain, offer; also owns the pending slot and overrun flag
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            k_q        <= '0;
            rd_issue   <= 1'b0;
            mem_addr   <= '0;
            drain_cnt  <= '0;
            tvalid     <= 1'b0;
            col_index  <= '0;
            pend_vld   <= 1'b0;
            pend_theta <= '0;
            overrun    <= 1'b0;
`ifdef TEST_PATTERN_EN
            theta_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (theta_valid) begin
                        state    <= FETCH;
                        rd_issue <= 1'b1;
                        k_q      <= '0;
                        mem_addr <= AW'(start_theta) * AW'(2*NUM_ROWS);
`ifdef TEST_PATTERN_EN
                        theta_q  <= start_theta;
`endif
                    end
                end
                FETCH: begin
                    if (k_q == K_LAST) begin
                        rd_issue  <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        k_q      <= k_q + KW'(1);
                        mem_addr <= mem_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= VALID;
                        tvalid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                VALID: begin
                    if (tready) begin
                        tvalid    <= 1'b0;
                        col_index <= (col_index == IDX_LAST) ? '0 : col_index + CW'(1);
                        if (theta_valid || pend_vld) begin
                            state    <= FETCH;
                            rd_issue <= 1'b1;
                            k_q      <= '0;
                            mem_addr <= AW'(start_theta) * AW'(2*NUM_ROWS);
`ifdef TEST_PATTERN_EN
                            theta_q  <= start_theta;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Strobes that cannot start a fetch right now go to the one-deep slot
            if (theta_valid && (state != IDLE) && !xfer) begin
                if (pend_vld) overrun <= 1'b1;
                pend_theta <= theta_in;
                pend_vld   <= 1'b1;
            end else if (xfer) begin
                pend_vld <= 1'b0;
            end
        end
    end

`ifdef TEST_PATTERN_EN
    assign mem_rd_en = 1'b0;
    assign cap_word  = RGB_RES'(theta_q + TW'(pipe_k[LAT-1]));
`else
    assign mem_rd_en = rd_issue;
    assign cap_word  = mem_rdata;
`endif

    // 2*NUM_ROWS is a power of two, so the index MSB selects the half
    assign cap_h = pipe_k[LAT-1][KW-1];
    assign cap_p = pipe_k[LAT-1][PW-1:0];

    // Delay the read tags by the BRAM latency and write each returning word into place
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_k[i]   <= '0;
            end
            column_data <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_k[0]   <= k_q;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_k[i]   <= pipe_k[i-1];
            end
            if (pipe_vld[LAT-1]) begin
                column_data[cap_h][cap_p] <= cap_word;
            end
        end
    end
endmodule

// File: tb/tb_column_fetch.sv
// Bench for column_fetch: directed strobes, a BRAM model returning addr[8:0], and a per-cycle column/address checker.
// Latency: every column is expected 131 cycles after the strobe that starts it.
// Backpressure: tready is held low to test hold-stability, then high for back-to-back transfers.
module tb_column_fetch;
    logic                    clk_in = 1'b0;
    logic                    rst_n_in;
    logic [9:0]              theta_in;
    logic                    theta_valid;
    logic [16:0]             mem_addr;
    logic                    mem_rd_en;
    logic [8:0]              mem_rdata = 9'h155;
    logic [1:0][63:0][8:0]   column_data;
    logic [4:0]              col_index;
    logic                    tvalid;
    logic                    tready;
    logic                    overrun;

    column_fetch dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .theta_in    (theta_in),
        .theta_valid (theta_valid),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .column_data (column_data),
        .col_index   (col_index),
        .tvalid      (tvalid),
        .tready      (tready),
        .overrun     (overrun)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model, two-cycle read latency; returns junk when no read was issued
    logic        bv1 = 1'b0;
    logic [16:0] ba1 = '0;
    always @(posedge clk_in) begin
        bv1       <= mem_rd_en;
        ba1       <= mem_addr;
        mem_rdata <= bv1 ? ba1[8:0] : 9'h155;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Expected column for a theta, straight from the addressing rule
    function automatic logic [1151:0] exp_column(input int th);
        logic [1151:0] r;
        int w;
        r = '0;
        for (int k = 0; k < 128; k++) begin
`ifdef TEST_PATTERN_EN
            w = (th + k) & 511;
`else
            w = (th * 128 + k) & 511;
`endif
            r[k*9 +: 9] = 9'(w);
        end
        return r;
    endfunction

    // Model state: columns expected to be offered, and columns expected to be read
    int exp_q[$];
    int fetch_q[$];
    int rd_k    = 0;
    int exp_col = 0;

    logic           prev_hold = 1'b0;
    logic [1151:0]  prev_data;
    logic [4:0]     prev_idx;

    // Per-cycle compare against the model
    always @(negedge clk_in) begin
        logic [1151:0] got, want;
        if (!rst_n_in) begin
            prev_hold = 1'b0;
        end else begin
`ifdef TEST_PATTERN_EN
            chk("tp_rd_en_low", mem_rd_en, 0);
`else
            if (mem_rd_en) begin
                if (fetch_q.size() == 0) begin
                    chk("unexpected_read_addr", mem_addr, -1);
                end else begin
                    chk("mem_addr", mem_addr, fetch_q[0] * 128 + rd_k);
                    rd_k++;
                    if (rd_k == 128) begin
                        rd_k = 0;
                        void'(fetch_q.pop_front());
                    end
                end
            end
`endif
            if (prev_hold) begin
                chk("hold_tvalid", tvalid, 1);
                chk("hold_col_index", col_index, prev_idx);
                n_checks++;
                if (column_data === prev_data) n_pass++;
                else $display("FAIL hold_column: column_data changed while stalled");
            end
            if (tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tvalid", tvalid, 0);
                end else begin
                    got  = column_data;
                    want = exp_column(exp_q[0]);
                    n_checks++;
                    if (got === want) n_pass++;
                    else begin
                        for (int k = 0; k < 128; k++) begin
                            if (got[k*9 +: 9] !== want[k*9 +: 9]) begin
                                $display("FAIL column theta=%0d word k=%0d: got %0d expected %0d",
                                         exp_q[0], k, got[k*9 +: 9], want[k*9 +: 9]);
                                break;
                            end
                        end
                    end
                    chk("col_index", col_index, exp_col);
                end
                prev_hold = !tready;
                prev_data = column_data;
                prev_idx  = col_index;
                if (tready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    exp_col = (exp_col + 1) % 32;
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Strobe theta in the current cycle (cycle 0) and return at the cycle tvalid is seen
    task automatic strobe_and_wait(input logic [9:0] th, output int lat,
                                   output logic frd, output logic [16:0] fad);
        theta_in    = th;
        theta_valid = 1'b1;
        exp_q.push_back(int'(th));
        fetch_q.push_back(int'(th));
        step(1);
        theta_valid = 1'b0;
        frd = mem_rd_en;
        fad = mem_addr;
        lat = 1;
        while (!tvalid && lat < 400) begin
            step(1);
            lat++;
        end
    endtask

    int          lat;
    logic        frd;
    logic [16:0] fad;

    initial begin
        rst_n_in    = 1'b0;
        theta_valid = 1'b0;
        theta_in    = '0;
        tready      = 1'b0;
        #12;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_col_index", col_index, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_column_zero", (column_data == '0) ? 1 : 0, 1);
        step(1);
        rst_n_in = 1'b1;
        step(1);

        // Single column, theta=5, stalled downstream
        strobe_and_wait(10'd5, lat, frd, fad);
        chk("t1_latency", lat, 131);
`ifdef TEST_PATTERN_EN
        chk("t1_first_rd_en", frd, 0);
        chk("t1_col_1_0", column_data[1][0], 69);
`else
        chk("t1_first_rd_en", frd, 1);
        chk("t1_first_addr", fad, 640);
        chk("t1_col_1_0", column_data[1][0], 192);
`endif

        // Hold for 50 cycles, then a single transfer
        step(50);
        chk("t2_still_valid", tvalid, 1);
        tready = 1'b1;
        step(1);
        tready = 1'b0;
        chk("t2_tvalid_dropped", tvalid, 0);
        chk("t2_col_index", col_index, 1);
        step(3);
        chk("t2_idle_tvalid", tvalid, 0);
        chk("t2_idle_rd_en", mem_rd_en, 0);

        // 33 back-to-back columns, strobes coinciding with transfers
        tready = 1'b1;
        strobe_and_wait(10'd100, lat, frd, fad);
        chk("t3_latency_first", lat, 131);
        for (int i = 1; i < 33; i++) begin
            strobe_and_wait(10'((100 + i * 29) & 1023), lat, frd, fad);
            chk("t3_latency", lat, 131);
`ifndef TEST_PATTERN_EN
            chk("t3_no_idle_cycle", frd, 1);
`endif
        end
        step(1);
        chk("t3_col_index_wrapped", col_index, 2);
        chk("t3_tvalid_low", tvalid, 0);

        // Pending slot overwrite: 3 during FETCH of 2, then 4 during DRAIN
        theta_in    = 10'd2;
        theta_valid = 1'b1;
        exp_q.push_back(2);
        fetch_q.push_back(2);
        step(1);
        theta_valid = 1'b0;
        step(19);
        theta_in    = 10'd3;
        theta_valid = 1'b1;
        step(1);
        theta_valid = 1'b0;
        chk("t4_no_overrun_yet", overrun, 0);
        step(108);
        theta_in    = 10'd4;
        theta_valid = 1'b1;
        exp_q.push_back(4);
        fetch_q.push_back(4);
        step(1);
        theta_valid = 1'b0;
        chk("t4_overrun_set", overrun, 1);
        chk("t4_drain_tvalid_low", tvalid, 0);
        step(1);
        chk("t4_tvalid_at_131", tvalid, 1);
        step(1);
        lat = 1;
        while (!tvalid && lat < 400) begin
            step(1);
            lat++;
        end
        chk("t4_pending_latency", lat, 131);
        step(1);
        chk("t4_overrun_sticky", overrun, 1);
        chk("t4_done_tvalid_low", tvalid, 0);

        // Reset in the middle of a fetch (k=40)
        theta_in    = 10'd9;
        theta_valid = 1'b1;
        exp_q.push_back(9);
        fetch_q.push_back(9);
        step(1);
        theta_valid = 1'b0;
        step(40);
        #2;
        rst_n_in = 1'b0;
        exp_q.delete();
        fetch_q.delete();
        rd_k    = 0;
        exp_col = 0;
        #1;
        chk("t5_rst_tvalid", tvalid, 0);
        chk("t5_rst_rd_en", mem_rd_en, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_col_index", col_index, 0);
        chk("t5_rst_overrun", overrun, 0);
        chk("t5_rst_column_zero", (column_data == '0) ? 1 : 0, 1);
        step(3);
        rst_n_in = 1'b1;
        step(1);
        strobe_and_wait(10'd7, lat, frd, fad);
        chk("t5_latency", lat, 131);
`ifdef TEST_PATTERN_EN
        chk("t5_col_0_0", column_data[0][0], 7);
`else
        chk("t5_col_0_0", column_data[0][0], 384);
`endif
        step(1);
        chk("t5_col_index", col_index, 1);

        // theta=10 literals (pattern mode values when enabled)
        strobe_and_wait(10'd10, lat, frd, fad);
        chk("t6_latency", lat, 131);
`ifdef TEST_PATTERN_EN
        chk("t6_col_0_3", column_data[0][3], 13);
        chk("t6_col_1_0", column_data[1][0], 74);
`else
        chk("t6_col_0_3", column_data[0][3], 259);
        chk("t6_col_1_0", column_data[1][0], 320);
`endif
        step(5);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
